// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg                                                                  |
// | Shared 640x480@60 timing constants, RRRGGGBB colour constants and the    |
// | 8-bit to 4:4:4 colour expansion helper used by vga_driver and graphics.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_pkg;

   // Default 640x480@60 timing (pixel clocks / lines)
   localparam int c_H_ACTIVE = 640;
   localparam int c_H_FP     = 16;
   localparam int c_H_SYNC   = 96;
   localparam int c_H_BP     = 48;
   localparam int c_V_ACTIVE = 480;
   localparam int c_V_FP     = 10;
   localparam int c_V_SYNC   = 2;
   localparam int c_V_BP     = 33;

   localparam int c_H_TOTAL      = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;  // 800
   localparam int c_V_TOTAL      = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;  // 525
   localparam int c_H_SYNC_START = c_H_ACTIVE + c_H_FP;                      // 656
   localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC - 1;            // 751
   localparam int c_V_SYNC_START = c_V_ACTIVE + c_V_FP;                      // 490
   localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC - 1;            // 491

   // RRRGGGBB colour constants shared with graphics
   localparam logic [7:0] BLK = 8'h00;
   localparam logic [7:0] WHT = 8'hFF;
   localparam logic [7:0] RED = 8'hE0;
   localparam logic [7:0] GRN = 8'h1C;
   localparam logic [7:0] BLU = 8'h03;
   localparam logic [7:0] YEL = 8'hFC;
   localparam logic [7:0] CYN = 8'h1F;
   localparam logic [7:0] MAG = 8'hE3;

   // Expand RRRGGGBB to {R4,G4,B4}: replicate MSBs to fill the low bits so
   // full-scale inputs map to full-scale outputs.
   function automatic logic [11:0] rgb444(input logic [7:0] c);
      return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_delay_line                                                           |
// | WIDTH x DEPTH shift register; every stage loads i_rst_val on reset.      |
// | Ports: clk, rst (sync, active high), i_rst_val[WIDTH], i_d[WIDTH],       |
// |        o_q[WIDTH] = i_d delayed by DEPTH clocks.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_rst_val,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= i_rst_val;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_driver                                                               |
// | Raster counters, pixel-aligned sync generation, RGB output stage,        |
// | per-frame tick and ghost animation toggle.                               |
// | Ports: clk, rst (sync, active high), color[8] RRRGGGBB from graphics,    |
// |        hc[10]/vc[10] raster counters, vga_r/g/b[4], hsync/vsync (active  |
// |        low), frame_tick (1 clk at vblank start), ghost_animation.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_driver
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = c_H_ACTIVE,
   parameter int H_FP        = c_H_FP,
   parameter int H_SYNC      = c_H_SYNC,
   parameter int H_BP        = c_H_BP,
   parameter int V_ACTIVE    = c_V_ACTIVE,
   parameter int V_FP        = c_V_FP,
   parameter int V_SYNC      = c_V_SYNC,
   parameter int V_BP        = c_V_BP,
   parameter int PIPE_DELAY  = 2,
   parameter int ANIM_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] color,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick,
   output logic       ghost_animation
);

   localparam logic [9:0] c_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] c_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [7:0] c_ANIM_LAST = 8'(ANIM_FRAMES - 1);

   logic [9:0]  r_hc;
   logic [9:0]  r_vc;
   logic        r_hsync;
   logic        r_vsync;
   logic [11:0] r_rgb;
   logic        r_tick;
   logic        r_ghost;
   logic [7:0]  r_anim;

   logic        w_hs_raw;
   logic        w_vs_raw;
   logic        w_blank_raw;
   logic [2:0]  w_dl_out;
   logic        w_tick;

   assign w_hs_raw    = !((r_hc >= c_HS_START) && (r_hc <= c_HS_END));
   assign w_vs_raw    = !((r_vc >= c_VS_START) && (r_vc <= c_VS_END));
   assign w_blank_raw = (r_hc >= c_H_ACT) || (r_vc >= c_V_ACT);

   // Counters sitting at the first blanked line start: the registered tick
   // and the animation update both fire on the following clock.
   assign w_tick = (r_hc == 10'd0) && (r_vc == c_V_ACT);

   // Sync/blank follow the maze RAM read so they meet the matching colour;
   // reset content is "not in sync, blanked".
   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_DELAY)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .i_rst_val (3'b111),
      .i_d       ({w_hs_raw, w_vs_raw, w_blank_raw}),
      .o_q       (w_dl_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hc    <= '0;
         r_vc    <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_rgb   <= '0;
         r_tick  <= 1'b0;
         r_ghost <= 1'b0;
         r_anim  <= '0;
      end else begin
         if (r_hc == c_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
         end else begin
            r_hc <= r_hc + 10'd1;
         end

         r_hsync <= w_dl_out[2];
         r_vsync <= w_dl_out[1];
         // Colour is only meaningful inside the visible area.
         r_rgb   <= w_dl_out[0] ? 12'h000 : rgb444(color);

         r_tick <= w_tick;
         if (w_tick) begin
            if (r_anim == c_ANIM_LAST) begin
               r_anim  <= '0;
               r_ghost <= ~r_ghost;
            end else begin
               r_anim <= r_anim + 8'd1;
            end
         end
      end
   end

   assign hc              = r_hc;
   assign vc              = r_vc;
   assign vga_r           = r_rgb[11:8];
   assign vga_g           = r_rgb[7:4];
   assign vga_b           = r_rgb[3:0];
   assign hsync           = r_hsync;
   assign vsync           = r_vsync;
   assign frame_tick      = r_tick;
   assign ghost_animation = r_ghost;

endmodule
`default_nettype wire

// File: tb/tb_vga_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_driver                                                            |
// | Self-checking bench for vga_driver using a shrunken raster so several    |
// | frames fit in a short run. Reference model derives every output from     |
// | the cycle count since reset release.                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_driver;

   localparam int HA = 20, HF = 3, HS = 5, HB = 4;
   localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;   // 32
   localparam int VT = VA + VF + VS + VB;   // 13
   localparam int FRAME = HT * VT;          // 416
   localparam int P = 2;
   localparam int ANIM = 2;
   localparam int HS_START = HA + HF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] color = 8'h00;
   logic [9:0] hc, vc;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       hsync, vsync, frame_tick, ghost_animation;

   vga_driver #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .PIPE_DELAY (P), .ANIM_FRAMES (ANIM)
   ) dut (
      .clk (clk), .rst (rst), .color (color),
      .hc (hc), .vc (vc),
      .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
      .hsync (hsync), .vsync (vsync),
      .frame_tick (frame_tick), .ghost_animation (ghost_animation)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // model / tracking state
   int         n = 0;
   int         exp_ticks = 0;
   logic [7:0] colhist [16];
   logic       exp_active = 1'b0;
   logic       rand_mode = 1'b1;
   logic [7:0] hold_color = 8'h00;
   int         obs_ticks, obs_toggles, obs_vs_low, hs_run, last_tick;
   logic       prev_hs, prev_ghost;

   typedef struct {
      logic [7:0] c;
      logic [3:0] r, g, b;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
   endtask

   function automatic logic [9:0] m_hc(input int t);
      return 10'(t % HT);
   endfunction

   function automatic logic [9:0] m_vc(input int t);
      return 10'((t / HT) % VT);
   endfunction

   task automatic check_cycle();
      logic [9:0]  ph, pv;
      logic        ehs, evs, eblank, etick, eghost;
      logic [7:0]  c;
      logic [11:0] ergb;
      if (n < P + 1) begin
         ehs = 1'b1; evs = 1'b1; eblank = 1'b1;
      end else begin
         ph = m_hc(n - P - 1);
         pv = m_vc(n - P - 1);
         ehs    = !(ph >= HS_START && ph < HS_START + HS);
         evs    = !(pv >= VA + VF && pv < VA + VF + VS);
         eblank = (ph >= HA) || (pv >= VA);
      end
      c = (n > 0) ? colhist[4'((n - 1) % 16)] : 8'h00;
      ergb = eblank ? 12'h000 : {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
      exp_active = !eblank;
      etick  = (n >= 1) && (m_hc(n - 1) == 10'd0) && (m_vc(n - 1) == 10'(VA));
      eghost = 1'(((exp_ticks / ANIM) % 2));
      chk("counters", 64'({hc, vc}), 64'({m_hc(n), m_vc(n)}));
      chk("pixel", 64'({hsync, vsync, vga_r, vga_g, vga_b}), 64'({ehs, evs, ergb}));
      chk("tick_ghost", 64'({frame_tick, ghost_animation}), 64'({etick, eghost}));
   endtask

   task automatic drive_color();
      color = rand_mode ? 8'($urandom) : hold_color;
      colhist[4'(n % 16)] = color;
   endtask

   task automatic step();
      @(posedge clk); #1;
      n++;
      if ((m_hc(n - 1) == 10'd0) && (m_vc(n - 1) == 10'(VA))) exp_ticks++;
      check_cycle();
      if (frame_tick) begin
         obs_ticks++;
         if (last_tick >= 0) chk("tick_spacing", 64'(n - last_tick), 64'(FRAME));
         last_tick = n;
      end
      if (ghost_animation !== prev_ghost) obs_toggles++;
      prev_ghost = ghost_animation;
      if (!vsync) obs_vs_low++;
      if (!hsync) begin
         if (prev_hs) chk("hsync_fall_latency", 64'(m_hc(n - P - 1)), 64'(HS_START));
         hs_run++;
      end else if (!prev_hs) begin
         chk("hsync_width", 64'(hs_run), 64'(HS));
         hs_run = 0;
      end
      prev_hs = hsync;
      drive_color();
   endtask

   task automatic clear_obs();
      obs_ticks = 0; obs_toggles = 0; obs_vs_low = 0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         chk("reset_hold",
             64'({hc, vc, hsync, vsync, vga_r, vga_g, vga_b, frame_tick, ghost_animation}),
             64'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}));
         color = 8'($urandom);
      end
      rst = 1'b0;
      n = 0; exp_ticks = 0; last_tick = -1; hs_run = 0;
      prev_hs = 1'b1; prev_ghost = 1'b0;
      check_cycle();
      drive_color();
   endtask

   initial begin
      bit found;
      int waited;

      tbl[0] = '{8'hE0, 4'hF, 4'h0, 4'h0};
      tbl[1] = '{8'h1C, 4'h0, 4'hF, 4'h0};
      tbl[2] = '{8'h03, 4'h0, 4'h0, 4'hF};
      tbl[3] = '{8'hFF, 4'hF, 4'hF, 4'hF};
      tbl[4] = '{8'h00, 4'h0, 4'h0, 4'h0};
      tbl[5] = '{8'h92, 4'h9, 4'h9, 4'hA};
      tbl[6] = '{8'h6D, 4'h6, 4'h6, 4'h5};
      tbl[7] = '{8'hA4, 4'hB, 4'h2, 4'h0};

      // Reset with random colour toggling underneath, then six random frames.
      do_reset(4);
      clear_obs();
      rand_mode = 1'b1;
      for (int i = 0; i < 6 * FRAME; i++) step();
      chk("tick_count_6frames", 64'(obs_ticks), 64'd6);
      chk("ghost_toggles_6frames", 64'(obs_toggles), 64'd3);
      chk("vsync_low_clocks", 64'(obs_vs_low), 64'(6 * VS * HT));

      // Table-driven colour expansion on a held colour.
      rand_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         hold_color = tbl[i].c;
         found = 1'b0;
         waited = 0;
         while (!found && waited < 2 * FRAME) begin
            step();
            waited++;
            if (waited >= 3 && exp_active) found = 1'b1;
         end
         if (!found) begin
            n_total++;
            $display("FAIL rgb_table[%0d]: no active pixel within %0d clocks", i, 2 * FRAME);
         end else begin
            chk($sformatf("rgb_table[%0d]", i), 64'({vga_r, vga_g, vga_b}),
                64'({tbl[i].r, tbl[i].g, tbl[i].b}));
         end
      end

      // Mid-frame one-clock reset while the animation counter is part way.
      rand_mode = 1'b1;
      found = 1'b0;
      waited = 0;
      while (!found && waited < 3 * FRAME) begin
         step();
         waited++;
         if ((exp_ticks % ANIM) == 1 && m_hc(n) == 10'd10 && m_vc(n) == 10'd4) found = 1'b1;
      end
      if (!found) begin
         n_total++;
         $display("FAIL midframe_position: hc=10 vc=4 with odd tick count not reached");
      end
      do_reset(1);
      clear_obs();
      for (int i = 0; i < 3 * FRAME; i++) step();
      chk("tick_count_after_reset", 64'(obs_ticks), 64'd3);
      chk("ghost_toggles_after_reset", 64'(obs_toggles), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
